// File: rtl/icache_pkg.sv
// Shared types and defaults for the direct-mapped instruction cache.
// Fill requests travel as a word address so the tag/index split lives with the storage.
package icache_pkg;

   typedef enum logic {
      IC_IDLE  = 1'b0,
      IC_FETCH = 1'b1
   } ic_state_e;

   localparam int IC_LINES = 16;
   localparam int IC_CNT_W = 16;

   typedef struct packed {
      logic        we;
      logic [29:0] waddr;
      logic [31:0] data;
   } ic_fill_t;

endpackage

// File: rtl/icache_if.sv
// Core fetch port and external memory port of the instruction cache.
// The cache is the slave of the fetch port and the master of the memory port.
interface icache_fetch_if;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        core_stall;

   modport master (output rom_ce, rom_addr, input rom_data, core_stall);
   modport slave  (input rom_ce, rom_addr, output rom_data, core_stall);
endinterface

interface icache_mem_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (output mem_req, mem_addr, input mem_ready, mem_rdata);
   modport slave  (input mem_req, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, one fill port, invalidate-all.
// Only the valid bits are reset; invalidate wins over a coincident fill.
module icache_array
   import icache_pkg::*;
#(
   parameter  int LINES = IC_LINES,
   localparam int IDX_W = $clog2(LINES),
   localparam int TAG_W = 30 - IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic             o_rd_valid,
   output logic [TAG_W-1:0] o_rd_tag,
   output logic [31:0]      o_rd_data,
   input  ic_fill_t         i_fill,
   input  logic             i_inv
);

   logic             r_valid [LINES];
   logic [TAG_W-1:0] r_tag   [LINES];
   logic [31:0]      r_data  [LINES];

   logic [IDX_W-1:0] w_wr_idx;
   logic [TAG_W-1:0] w_wr_tag;
   logic [LINES-1:0] w_we_line;

   assign w_wr_idx  = i_fill.waddr[IDX_W-1:0];
   assign w_wr_tag  = i_fill.waddr[29:IDX_W];
   assign w_we_line = i_fill.we ? (LINES'(1) << w_wr_idx) : '0;

   for (genvar g = 0; g < LINES; g++) begin : g_line
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)             r_valid[g] <= 1'b0;
         else if (i_inv)         r_valid[g] <= 1'b0;
         else if (w_we_line[g])  r_valid[g] <= 1'b1;
      end

      always_ff @(posedge clk) begin
         if (w_we_line[g]) begin
            r_tag[g]  <= w_wr_tag;
            r_data[g] <= i_fill.data;
         end
      end
   end

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped single-word-line I-cache: same-cycle hits, stall plus one
// outstanding external fetch on a miss, saturating miss counter.
module icache
   import icache_pkg::*;
#(
   parameter  int LINES = IC_LINES,
   parameter  int CNT_W = IC_CNT_W,
   localparam int IDX_W = $clog2(LINES),
   localparam int TAG_W = 30 - IDX_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_inv,
   icache_fetch_if.slave      fetch,
   icache_mem_if.master       mem,
   output logic [CNT_W-1:0]   o_miss_cnt
);

   ic_state_e        r_state, w_state_nxt;
   logic [29:0]      r_miss_addr;
   logic [CNT_W-1:0] r_miss_cnt;

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic             w_rd_valid;
   logic [TAG_W-1:0] w_rd_tag;
   logic [31:0]      w_rd_data;
   logic             w_hit;
   logic             w_stall;
   logic             w_launch;
   logic             w_fill_en;
   ic_fill_t         w_fill;
   logic             w_unused_ok;

   assign w_idx       = fetch.rom_addr[IDX_W+1:2];
   assign w_tag       = fetch.rom_addr[31:IDX_W+2];
   assign w_unused_ok = &{1'b0, fetch.rom_addr[1:0]};

   assign w_fill.we    = w_fill_en;
   assign w_fill.waddr = r_miss_addr;
   assign w_fill.data  = mem.mem_rdata;

   icache_array #(.LINES(LINES)) u_array (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd_idx   (w_idx),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_data  (w_rd_data),
      .i_fill     (w_fill),
      .i_inv      (i_inv)
   );

   // Lookup is purely combinational so a hit keeps single-cycle ROM timing.
   assign w_hit            = fetch.rom_ce & w_rd_valid & (w_rd_tag == w_tag);
   assign w_stall          = fetch.rom_ce & ~w_hit;
   assign fetch.core_stall = w_stall;
   assign fetch.rom_data   = w_hit ? w_rd_data : 32'h0;

   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_fill_en   = 1'b0;
      case (r_state)
         IC_IDLE: begin
            if (w_stall) begin
               w_state_nxt = IC_FETCH;
               w_launch    = 1'b1;
            end
         end
         IC_FETCH: begin
            if (mem.mem_ready) begin
               w_fill_en   = 1'b1;
               w_state_nxt = IC_IDLE;
            end
         end
         default: w_state_nxt = IC_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IC_IDLE;
         r_miss_addr <= '0;
         r_miss_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_launch) begin
            r_miss_addr <= fetch.rom_addr[31:2];
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
         end
      end
   end

   // Request is decoded from registers only; the latched address keeps it stable.
   assign mem.mem_req  = (r_state == IC_FETCH);
   assign mem.mem_addr = {r_miss_addr, 2'b00};
   assign o_miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, alias eviction, retarget during
// fetch, invalidate racing a fill, and reset in the middle of a fetch.
module tb_icache;

   logic        clk;
   logic        rst_n;
   logic        inv;
   logic [15:0] miss_cnt;
   int          n_tests;
   int          n_fail;

   icache_fetch_if fif ();
   icache_mem_if   mif ();

   icache #(.LINES(16), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_inv      (inv),
      .fetch      (fif),
      .mem        (mif),
      .o_miss_cnt (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents addr from IDLE, expects a miss, answers with k=0 and checks the hit.
   task automatic do_miss(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [15:0] cnt_exp);
      fif.rom_ce   = 1'b1;
      fif.rom_addr = addr;
      #1;
      chk({tag, "_stall0"}, 32'(fif.core_stall), 32'h1);
      chk({tag, "_req0"},   32'(mif.mem_req),    32'h0);
      tick();
      chk({tag, "_req1"},   32'(mif.mem_req),    32'h1);
      chk({tag, "_maddr"},  mif.mem_addr,        addr);
      chk({tag, "_cnt"},    32'(miss_cnt),       32'(cnt_exp));
      mif.mem_ready = 1'b1;
      mif.mem_rdata = data;
      tick();
      mif.mem_ready = 1'b0;
      mif.mem_rdata = 32'h0;
      #1;
      chk({tag, "_hitstall"}, 32'(fif.core_stall), 32'h0);
      chk({tag, "_hitdata"},  fif.rom_data,        data);
      chk({tag, "_reqdone"},  32'(mif.mem_req),    32'h0);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      inv           = 1'b0;
      fif.rom_ce    = 1'b0;
      fif.rom_addr  = 32'h0;
      mif.mem_ready = 1'b0;
      mif.mem_rdata = 32'h0;

      // Reset state
      #2;
      chk("rst_req",   32'(mif.mem_req),    32'h0);
      chk("rst_maddr", mif.mem_addr,        32'h0);
      chk("rst_cnt",   32'(miss_cnt),       32'h0);
      chk("rst_stall", 32'(fif.core_stall), 32'h0);
      chk("rst_data",  fif.rom_data,        32'h0);
      fif.rom_ce   = 1'b1;
      fif.rom_addr = 32'h40;
      #1;
      chk("rst_stall_ce", 32'(fif.core_stall), 32'h1);
      fif.rom_ce = 1'b0;
      #9;
      rst_n = 1'b1;

      // Cold miss, mem_ready one cycle after mem_req
      tick();
      fif.rom_ce   = 1'b1;
      fif.rom_addr = 32'h40;
      #1;
      chk("cold_t0_stall", 32'(fif.core_stall), 32'h1);
      chk("cold_t0_req",   32'(mif.mem_req),    32'h0);
      tick();
      chk("cold_t1_stall", 32'(fif.core_stall), 32'h1);
      chk("cold_t1_req",   32'(mif.mem_req),    32'h1);
      chk("cold_t1_maddr", mif.mem_addr,        32'h40);
      chk("cold_t1_cnt",   32'(miss_cnt),       32'h1);
      tick();
      mif.mem_ready = 1'b1;
      mif.mem_rdata = 32'h24010005;
      #1;
      chk("cold_t2_stall", 32'(fif.core_stall), 32'h1);
      chk("cold_t2_maddr", mif.mem_addr,        32'h40);
      tick();
      mif.mem_ready = 1'b0;
      mif.mem_rdata = 32'h0;
      #1;
      chk("cold_t3_stall", 32'(fif.core_stall), 32'h0);
      chk("cold_t3_data",  fif.rom_data,        32'h24010005);
      chk("cold_t3_req",   32'(mif.mem_req),    32'h0);
      chk("cold_t3_cnt",   32'(miss_cnt),       32'h1);

      // Idle core, then hit after fill
      tick();
      fif.rom_ce = 1'b0;
      #1;
      chk("noce_data",  fif.rom_data,        32'h0);
      chk("noce_stall", 32'(fif.core_stall), 32'h0);
      tick();
      fif.rom_ce   = 1'b1;
      fif.rom_addr = 32'h43;
      #1;
      chk("hit_data",  fif.rom_data,        32'h24010005);
      chk("hit_stall", 32'(fif.core_stall), 32'h0);
      tick();
      chk("hit_req", 32'(mif.mem_req), 32'h0);
      chk("hit_cnt", 32'(miss_cnt),    32'h1);

      // Alias eviction on index 0
      do_miss("alias80", 32'h80, 32'h11112222, 16'd2);
      do_miss("alias40", 32'h40, 32'h24010005, 16'd3);
      fif.rom_addr = 32'h80;
      #1;
      chk("alias80_evicted", 32'(fif.core_stall), 32'h1);
      fif.rom_ce = 1'b0;
      tick();

      // Address change during FETCH does not retarget
      fif.rom_ce   = 1'b1;
      fif.rom_addr = 32'h100;
      tick();
      chk("retgt_req", 32'(mif.mem_req), 32'h1);
      fif.rom_addr = 32'h104;
      #1;
      chk("retgt_maddr_a", mif.mem_addr,        32'h100);
      chk("retgt_stall",   32'(fif.core_stall), 32'h1);
      tick();
      chk("retgt_maddr_b", mif.mem_addr, 32'h100);
      mif.mem_ready = 1'b1;
      mif.mem_rdata = 32'hAAAA0100;
      tick();
      mif.mem_ready = 1'b0;
      #1;
      chk("retgt_idle_req",  32'(mif.mem_req),    32'h0);
      chk("retgt_104_stall", 32'(fif.core_stall), 32'h1);
      tick();
      chk("retgt_104_req",   32'(mif.mem_req), 32'h1);
      chk("retgt_104_maddr", mif.mem_addr,     32'h104);
      chk("retgt_cnt",       32'(miss_cnt),    32'h5);
      mif.mem_ready = 1'b1;
      mif.mem_rdata = 32'hBBBB0104;
      tick();
      mif.mem_ready = 1'b0;
      #1;
      chk("retgt_104_data", fif.rom_data, 32'hBBBB0104);
      fif.rom_addr = 32'h100;
      #1;
      chk("retgt_100_data", fif.rom_data, 32'hAAAA0100);

      // inv coinciding with mem_ready: written but not valid
      fif.rom_addr = 32'h200;
      tick();
      chk("inv_req", 32'(mif.mem_req), 32'h1);
      mif.mem_ready = 1'b1;
      mif.mem_rdata = 32'hCCCC0200;
      inv           = 1'b1;
      tick();
      mif.mem_ready = 1'b0;
      inv           = 1'b0;
      #1;
      chk("inv_idle",  32'(mif.mem_req),    32'h0);
      chk("inv_stall", 32'(fif.core_stall), 32'h1);
      chk("inv_data",  fif.rom_data,        32'h0);
      fif.rom_addr = 32'h104;
      #1;
      chk("inv_104_gone", 32'(fif.core_stall), 32'h1);
      fif.rom_addr = 32'h200;
      tick();
      chk("inv_refetch_req",   32'(mif.mem_req), 32'h1);
      chk("inv_refetch_maddr", mif.mem_addr,     32'h200);
      chk("inv_refetch_cnt",   32'(miss_cnt),    32'h7);
      mif.mem_ready = 1'b1;
      mif.mem_rdata = 32'hCCCC0200;
      tick();
      mif.mem_ready = 1'b0;
      #1;
      chk("inv_refetch_data", fif.rom_data, 32'hCCCC0200);

      // Reset in the middle of a FETCH
      fif.rom_addr = 32'h300;
      tick();
      chk("rmid_req", 32'(mif.mem_req), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rmid_req_drop", 32'(mif.mem_req), 32'h0);
      chk("rmid_maddr",    mif.mem_addr,     32'h0);
      chk("rmid_cnt",      32'(miss_cnt),    32'h0);
      fif.rom_ce = 1'b0;
      tick();
      rst_n         = 1'b1;
      mif.mem_ready = 1'b1;
      mif.mem_rdata = 32'hDEADBEEF;
      tick();
      mif.mem_ready = 1'b0;
      #1;
      chk("rmid_post_req", 32'(mif.mem_req), 32'h0);
      fif.rom_ce   = 1'b1;
      fif.rom_addr = 32'h200;
      #1;
      chk("rmid_200_stall", 32'(fif.core_stall), 32'h1);
      chk("rmid_200_data",  fif.rom_data,        32'h0);
      fif.rom_addr = 32'h300;
      #1;
      chk("rmid_300_stall", 32'(fif.core_stall), 32'h1);
      chk("rmid_300_data",  fif.rom_data,        32'h0);
      fif.rom_ce = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
